// File: rtl/global_buffer_param.sv
// Default widths and depths shared by the GLB load-DMA blocks.
package global_buffer_param;

    localparam int GLB_ADDR_WIDTH      = 22;
    localparam int LOOP_LEVEL          = 4;
    localparam int MAX_NUM_WORDS_WIDTH = 16;
    localparam int MAX_STRIDE_WIDTH    = 10;
    localparam int BANK_BYTE_OFFSET    = 3;

endpackage

// File: rtl/global_buffer_pkg.sv
// Shared GLB types: N-level load-DMA header and load walker states.
package global_buffer_pkg;

    import global_buffer_param::*;

    typedef struct packed {
        logic [MAX_NUM_WORDS_WIDTH-1:0] range;
        logic [MAX_STRIDE_WIDTH-1:0]    stride;
    } loop_ctrl_t;

    typedef struct packed {
        logic                           valid;
        logic [GLB_ADDR_WIDTH-1:0]      start_addr;
        loop_ctrl_t [LOOP_LEVEL-1:0]    loop_ctrl;
        logic [MAX_NUM_WORDS_WIDTH-1:0] num_active_words;
        logic [MAX_NUM_WORDS_WIDTH-1:0] num_inactive_words;
    } dma_ld_header_nd_t;

    typedef enum logic [1:0] {
        LD_IDLE     = 2'd0,
        LD_ACTIVE   = 2'd1,
        LD_INACTIVE = 2'd2,
        LD_DONE     = 2'd3
    } ld_state_t;

endpackage

// File: rtl/glb_loop_iter.sv
// Nested-loop odometer with per-level byte-offset accumulators; offsets are
// built incrementally so no multipliers are needed.
module glb_loop_iter #(
    parameter int GLB_ADDR_WIDTH      = 22,
    parameter int LOOP_LEVEL          = 4,
    parameter int MAX_NUM_WORDS_WIDTH = 16,
    parameter int MAX_STRIDE_WIDTH    = 10,
    parameter int BANK_BYTE_OFFSET    = 3
) (
    input  logic                                      clk,
    input  logic                                      reset_n,
    input  logic                                      clr_i,
    input  logic                                      step_i,
    input  logic [LOOP_LEVEL*MAX_NUM_WORDS_WIDTH-1:0] range_i,
    input  logic [LOOP_LEVEL*MAX_STRIDE_WIDTH-1:0]    stride_i,
    output logic                                      last_o,
    output logic [GLB_ADDR_WIDTH-1:0]                 offset_sum_o
);

    localparam int NW = MAX_NUM_WORDS_WIDTH;
    localparam int SW = MAX_STRIDE_WIDTH;
    localparam int GW = GLB_ADDR_WIDTH;

    logic [LOOP_LEVEL-1:0] wrap;
    logic [LOOP_LEVEL-1:0] carry;
    logic [GW-1:0]         off_next [LOOP_LEVEL];

    for (genvar gi = 0; gi < LOOP_LEVEL; gi++) begin : g_lvl
        // A level advances only when every inner level is at its last value.
        localparam logic [LOOP_LEVEL-1:0] LOWER = LOOP_LEVEL'((1 << gi) - 1);

        logic [NW-1:0] rng;
        logic [NW-1:0] rng_m1;
        logic [NW-1:0] itr_q;
        logic [NW-1:0] itr_d;
        logic [GW-1:0] stride_bytes;
        logic [GW-1:0] off_q;
        logic [GW-1:0] off_d;

        assign rng          = range_i[gi*NW +: NW];
        assign rng_m1       = (rng == '0) ? '0 : rng - 1'b1;
        assign wrap[gi]     = (itr_q == rng_m1);
        assign carry[gi]    = step_i & (&(wrap | ~LOWER));
        assign stride_bytes = GW'(stride_i[gi*SW +: SW]) << BANK_BYTE_OFFSET;
        assign itr_d        = !carry[gi] ? itr_q : (wrap[gi] ? '0 : itr_q + 1'b1);
        assign off_d        = !carry[gi] ? off_q : (wrap[gi] ? '0 : off_q + stride_bytes);
        assign off_next[gi] = off_d;

        always_ff @(posedge clk) begin
            if (!reset_n || clr_i) begin
                itr_q <= '0;
                off_q <= '0;
            end else begin
                itr_q <= itr_d;
                off_q <= off_d;
            end
        end
    end

    assign last_o = &wrap;

    always_comb begin
        offset_sum_o = '0;
        for (int i = 0; i < LOOP_LEVEL; i++) begin
            offset_sum_o = offset_sum_o + off_next[i];
        end
    end

endmodule

// File: rtl/glb_ld_addr_gen_nd.sv
// N-level GLB load-DMA address generator: latches a header on start and walks
// the nested loop, with duty-cycling, backpressure, abort and a done pulse.
module glb_ld_addr_gen_nd
    import global_buffer_pkg::*;
#(
    parameter int GLB_ADDR_WIDTH      = global_buffer_param::GLB_ADDR_WIDTH,
    parameter int LOOP_LEVEL          = global_buffer_param::LOOP_LEVEL,
    parameter int MAX_NUM_WORDS_WIDTH = global_buffer_param::MAX_NUM_WORDS_WIDTH,
    parameter int MAX_STRIDE_WIDTH    = global_buffer_param::MAX_STRIDE_WIDTH,
    parameter int BANK_BYTE_OFFSET    = global_buffer_param::BANK_BYTE_OFFSET
) (
    input  logic                                      clk,
    input  logic                                      reset_n,
    input  logic                                      start_pulse,
    input  logic                                      cfg_valid,
    input  logic [GLB_ADDR_WIDTH-1:0]                 cfg_start_addr,
    input  logic [LOOP_LEVEL*MAX_NUM_WORDS_WIDTH-1:0] cfg_range,
    input  logic [LOOP_LEVEL*MAX_STRIDE_WIDTH-1:0]    cfg_stride,
    input  logic [MAX_NUM_WORDS_WIDTH-1:0]            cfg_num_active_words,
    input  logic [MAX_NUM_WORDS_WIDTH-1:0]            cfg_num_inactive_words,
    input  logic                                      abort,
    input  logic                                      rdrq_ready,
    output logic                                      rdrq_en,
    output logic [GLB_ADDR_WIDTH-1:0]                 rdrq_addr,
    output logic                                      busy,
    output logic                                      done_pulse
);

    localparam int NW = MAX_NUM_WORDS_WIDTH;
    localparam int GW = GLB_ADDR_WIDTH;

    ld_state_t state_q, state_d;

    logic [GW-1:0]                 start_q;
    logic [GW-1:0]                 addr_q, addr_d;
    logic [LOOP_LEVEL*NW-1:0]      range_q;
    logic [LOOP_LEVEL*MAX_STRIDE_WIDTH-1:0] stride_q;
    logic [NW-1:0]                 num_act_q;
    logic [NW-1:0]                 num_inact_q;
    logic [NW-1:0]                 act_cnt_q, act_cnt_d;
    logic [NW-1:0]                 inact_cnt_q, inact_cnt_d;

    logic          load;
    logic          step;
    logic          last;
    logic [GW-1:0] off_sum;

    assign load = (state_q == LD_IDLE) && start_pulse && cfg_valid;
    // Abort wins over an accept in the same cycle: the walker does not move.
    assign step = (state_q == LD_ACTIVE) && rdrq_ready && !abort;

    glb_loop_iter #(
        .GLB_ADDR_WIDTH     (GLB_ADDR_WIDTH),
        .LOOP_LEVEL         (LOOP_LEVEL),
        .MAX_NUM_WORDS_WIDTH(MAX_NUM_WORDS_WIDTH),
        .MAX_STRIDE_WIDTH   (MAX_STRIDE_WIDTH),
        .BANK_BYTE_OFFSET   (BANK_BYTE_OFFSET)
    ) u_iter (
        .clk         (clk),
        .reset_n     (reset_n),
        .clr_i       (load),
        .step_i      (step),
        .range_i     (range_q),
        .stride_i    (stride_q),
        .last_o      (last),
        .offset_sum_o(off_sum)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        act_cnt_d   = act_cnt_q;
        inact_cnt_d = inact_cnt_q;
        case (state_q)
            LD_IDLE: begin
                if (start_pulse && cfg_valid) begin
                    state_d     = LD_ACTIVE;
                    addr_d      = cfg_start_addr;
                    act_cnt_d   = '0;
                    inact_cnt_d = '0;
                end
            end
            LD_ACTIVE: begin
                if (abort) begin
                    state_d = LD_IDLE;
                end else if (rdrq_ready) begin
                    addr_d    = start_q + off_sum;
                    act_cnt_d = act_cnt_q + 1'b1;
                    if (last) begin
                        state_d = LD_DONE;
                    end else if ((num_act_q != '0) && (act_cnt_d == num_act_q)) begin
                        act_cnt_d = '0;
                        if (num_inact_q != '0) begin
                            state_d     = LD_INACTIVE;
                            inact_cnt_d = '0;
                        end
                    end
                end
            end
            LD_INACTIVE: begin
                if (abort) begin
                    state_d = LD_IDLE;
                end else if (inact_cnt_q == num_inact_q - 1'b1) begin
                    state_d = LD_ACTIVE;
                end else begin
                    inact_cnt_d = inact_cnt_q + 1'b1;
                end
            end
            LD_DONE: state_d = LD_IDLE;
            default: state_d = LD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= LD_IDLE;
            addr_q      <= '0;
            start_q     <= '0;
            range_q     <= '0;
            stride_q    <= '0;
            num_act_q   <= '0;
            num_inact_q <= '0;
            act_cnt_q   <= '0;
            inact_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            act_cnt_q   <= act_cnt_d;
            inact_cnt_q <= inact_cnt_d;
            if (load) begin
                start_q     <= cfg_start_addr;
                range_q     <= cfg_range;
                stride_q    <= cfg_stride;
                num_act_q   <= cfg_num_active_words;
                num_inact_q <= cfg_num_inactive_words;
            end
        end
    end

    assign rdrq_en    = (state_q == LD_ACTIVE);
    assign rdrq_addr  = addr_q;
    assign busy       = (state_q != LD_IDLE);
    assign done_pulse = (state_q == LD_DONE);

endmodule

// File: doc/glb_ld_addr_gen_nd.md
Name: glb_ld_addr_gen_nd

Overview:
Parametrised N-level load-DMA address generator for one GLB tile; the successor to the fixed-depth dma_ld_header_t walker. It latches a load header on start and emits a stream of SRAM read requests (rdrq_packet_t fields) over an up-to-LOOP_LEVEL nested affine loop. It adds active/inactive duty-cycling, ready backpressure, abort and a done pulse. It sits between the tile config registers and the bank read-request mux.

Parameters:
GLB_ADDR_WIDTH, 22, byte address width of rdrq_addr
LOOP_LEVEL, 4, number of nested loop levels (1..8)
MAX_NUM_WORDS_WIDTH, 16, width of each range and of the active/inactive counts
MAX_STRIDE_WIDTH, 10, width of each stride (in words)
BANK_BYTE_OFFSET, 3, log2 of bytes per word; strides are shifted left by this amount

Ports:
clk  in  1  clock
reset_n  in  1  synchronous, active-low reset
start_pulse  in  1  one-cycle start request
cfg_valid  in  1  header valid bit
cfg_start_addr  in  GLB_ADDR_WIDTH  byte start address
cfg_range  in  LOOP_LEVEL*MAX_NUM_WORDS_WIDTH  per-level iteration count; level 0 is in the LSBs and is innermost
cfg_stride  in  LOOP_LEVEL*MAX_STRIDE_WIDTH  per-level stride in words
cfg_num_active_words  in  MAX_NUM_WORDS_WIDTH  requests per burst; 0 means no gating
cfg_num_inactive_words  in  MAX_NUM_WORDS_WIDTH  idle cycles between bursts
abort  in  1  cancel the current transfer
rdrq_ready  in  1  downstream accepts a request
rdrq_en  out  1  read request valid
rdrq_addr  out  GLB_ADDR_WIDTH  read byte address
busy  out  1  transfer in progress
done_pulse  out  1  one cycle after the last accepted request

Behaviour:
- Reset (reset_n=0 at a clk edge): state=IDLE; rdrq_en=0, rdrq_addr=0, busy=0, done_pulse=0; all counters cleared. Reset overrides every other input, including mid-transfer.
- States: IDLE, ACTIVE, INACTIVE, DONE.
- IDLE: start_pulse=1 and cfg_valid=1 -> latch all cfg_* inputs, load itr[i]=0 and addr=cfg_start_addr, go to ACTIVE; busy=1 from the next cycle. start_pulse while cfg_valid=0 is ignored.
- start_pulse outside IDLE is ignored. Latched config is immune to later cfg_* changes.
- ACTIVE: rdrq_en=1 and rdrq_addr=current addr. A request is accepted when rdrq_en=1 and rdrq_ready=1. With no accept, rdrq_addr and all counters hold.
- On accept:
  - Increment loop counters odometer-style: itr[0]++; on itr[i]==range_eff[i]-1, itr[i] resets to 0 and carries into level i+1.
  - range_eff[i] = (cfg_range[i]==0) ? 1 : cfg_range[i]; a zero range disables that level.
  - Address update is incremental, with no multipliers: per-level offset accumulators off[i] += stride[i]<<BANK_BYTE_OFFSET; when a level wraps, off[i] clears.
  - addr = start_addr + sum(off[i]), truncated modulo 2^GLB_ADDR_WIDTH. Wrap-around is legal and silent.
  - active_cnt++.
- Last word: accept with every itr[i]==range_eff[i]-1 -> DONE. This has priority over the duty-cycle transition.
- Duty cycle: num_active>0 and active_cnt reaches num_active on an accept -> INACTIVE with inact_cnt=0 and active_cnt cleared.
  - If num_inactive==0, stay in ACTIVE; only active_cnt clears.
  - num_active==0 -> never leave ACTIVE except to DONE.
- INACTIVE: rdrq_en=0. Counts clock cycles regardless of rdrq_ready. After exactly num_inactive cycles -> ACTIVE.
- DONE: done_pulse=1 and rdrq_en=0 for one cycle, then IDLE with busy=0. Earliest restart is the cycle after DONE.
- abort=1 in ACTIVE/INACTIVE -> IDLE next cycle: rdrq_en=0, busy=0, no done_pulse.
  - An accept in the same cycle as abort still counts downstream, but the walker does not advance.
  - abort in IDLE or DONE has no effect.
- Latency: first rdrq_en is 1 cycle after the start edge. Sustained throughput is 1 request per cycle while ready=1.
- Outputs are registered; no combinational path from rdrq_ready to rdrq_en.

Decomposition:
- Shared package global_buffer_pkg gains:
  - a parametrised dma_ld_header_nd_t: valid, start_addr, loop_ctrl_t[LOOP_LEVEL], num_active_words, num_inactive_words;
  - ld_state_t enum {LD_IDLE, LD_ACTIVE, LD_INACTIVE, LD_DONE}.
- LOOP_LEVEL, MAX_STRIDE_WIDTH and BANK_BYTE_OFFSET defaults live in global_buffer_param.
- One sub-module, glb_loop_iter: the LOOP_LEVEL odometer plus offset accumulators, with step in and last/offset_sum out. The top module holds the FSM and duty-cycle counters.

Test Plan:
1. start_addr=0x100, range={4,1,1,1}, stride0=1, active=0, ready=1 -> rdrq_addr 0x100, 0x108, 0x110, 0x118 on consecutive cycles; done_pulse 1 cycle after the last request; busy low afterwards.
2. range0=2, stride0=1, range1=3, stride1=16 -> addrs 0x000, 0x008, 0x080, 0x088, 0x100, 0x108, then done.
3. range0=8, active=2, inactive=3, ready=1 -> pattern of 2 en cycles then 3 idle cycles, repeated; 8 requests total; done after the 8th (no trailing inactive gap).
4. range0=4, ready toggling 1,0,0,1,1,0,1 -> rdrq_addr holds while ready=0; exactly 4 accepts; addresses are monotonic with no skipped or duplicated address.
5. abort asserted on the 3rd request of range0=10 -> rdrq_en=0 and busy=0 next cycle, no done_pulse; a new start then begins again at the new start_addr.
6. start_addr=0x3FFFF8 (22-bit), range0=3, stride0=1 -> addrs 0x3FFFF8, 0x000000, 0x000008; also reset_n=0 mid-transfer -> all outputs 0 next cycle.
